lfsr_rng: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator, successor to the fixed 8-bit button-stepped generator. Adds configurable width, taps and seed, a synchronised push-button step input, a free-running mode with programmable step divider, and a runtime seed load. It sits between the board I/O (button, switches) and display/game logic. It provides a registered random word plus a one-cycle valid strobe.

---
 rtl/lfsr_rng.sv | 138 +++++++++++++
 tb/tb_lfsr_rng.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random generator: button-stepped or free-running with a programmable
// divider, runtime seed load with zero-lock guard. Define RNG_DEBOUNCE_EN to add a debounce filter.
module lfsr_rng #(
    parameter int unsigned WIDTH           = 8,
    parameter logic [31:0] TAPS            = 32'h1D,
    parameter logic [31:0] SEED            = 32'hFF,
    parameter int unsigned DIV_W           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             mode,
    input  logic [DIV_W-1:0] div,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] rnd_out,
    output logic             rnd_valid
);

    localparam logic [WIDTH-1:0] TAPS_L = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_L = SEED[WIDTH-1:0];

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             lvl;
    logic             rise_c;
    logic [WIDTH-1:0] state_q, state_d;
    logic             valid_q, valid_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             div_hit;
    logic             step;
    logic             fb;
    logic [WIDTH-1:0] lfsr_next;

    // Two-flop synchroniser for the asynchronous push-button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

`ifdef RNG_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_lvl_q, deb_lvl_d;

    // Level flips only after the synchronised input has disagreed for the full window
    always_comb begin
        deb_cnt_d = '0;
        deb_lvl_d = deb_lvl_q;
        if (sync2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_lvl_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_q <= '0;
            deb_lvl_q <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            deb_lvl_q <= deb_lvl_d;
        end
    end

    assign lvl = deb_lvl_q;
`else
    logic unused_deb;

    assign lvl        = sync2_q;
    assign unused_deb = (DEBOUNCE_CYCLES != 0);
`endif

    // Rising-edge detect on the (possibly debounced) button level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign rise_c    = lvl & ~prev_q;
    assign div_hit   = (cnt_q == div);
    assign step      = mode ? div_hit : rise_c;
    assign fb        = ^(state_q & TAPS_L);
    assign lfsr_next = {fb, state_q[WIDTH-1:1]};

    // Seed load beats step; the divider idles at zero outside free-run so a mode change restarts it
    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        if (seed_load) begin
            state_d = (seed == '0) ? SEED_L : seed;
            valid_d = 1'b1;
            cnt_d   = '0;
        end else begin
            if (step) begin
                state_d = lfsr_next;
                valid_d = 1'b1;
            end
            if (!mode || div_hit) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED_L;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rnd_out   = state_q;
    assign rnd_valid = valid_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_lfsr_rng;
    localparam int unsigned W  = 8;
    localparam int unsigned DW = 16;
    localparam logic [W-1:0] TAPS_M = 8'h1D;
    localparam logic [W-1:0] SEED_M = 8'hFF;
`ifdef RNG_DEBOUNCE_EN
    localparam int DEB = 16;
`else
    localparam int DEB = 0;
`endif
    localparam int LAT = DEB + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          button = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] div = '0;
    logic          seed_load = 1'b0;
    logic [W-1:0]  seed = '0;
    logic [W-1:0]  rnd_out;
    logic          rnd_valid;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    lfsr_rng #(
        .WIDTH(W), .TAPS(32'h1D), .SEED(32'hFF), .DIV_W(DW), .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .mode(mode), .div(div),
        .seed_load(seed_load), .seed(seed), .rnd_out(rnd_out), .rnd_valid(rnd_valid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_state;
    bit           m_valid;
    bit           btn_s[$];   // button sampled at each edge since reset
    bit           lvl_s[$];   // level seen by the edge detector after each edge
    int unsigned  run_k;      // free-run edges since the divider was last cleared

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
        int ones;
        ones = $countones(s & TAPS_M);
        return W'((s >> 1) | (W'(ones % 2) << (W - 1)));
    endfunction

    function automatic bit sync2_after(input int k);
        if (k - 1 < 0) return 1'b0;
        return btn_s[k-1];
    endfunction

    function automatic bit lvl_at(input int k);
        if (k < 0) return 1'b0;
        return lvl_s[k];
    endfunction

    task automatic model_edge();
        int n;
        bit lv, rise, stp, all_diff;
        n = btn_s.size();
        btn_s.push_back(button);
        if (DEB == 0) begin
            lv = sync2_after(n);
        end else begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (sync2_after(n - 1 - j) == lvl_at(n - 1)) all_diff = 1'b0;
            lv = all_diff ? ~lvl_at(n - 1) : lvl_at(n - 1);
        end
        lvl_s.push_back(lv);
        rise = lvl_at(n - 1) & ~lvl_at(n - 2);
        if (seed_load) begin
            m_state = (seed == '0) ? SEED_M : seed;
            m_valid = 1'b1;
            run_k   = 0;
        end else begin
            if (mode) begin
                stp = ((run_k % (int'(div) + 1)) == int'(div));
                run_k++;
            end else begin
                stp   = rise;
                run_k = 0;
            end
            if (stp) m_state = lfsr_step(m_state);
            m_valid = stp;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_state = SEED_M;
                m_valid = 1'b0;
                btn_s.delete();
                lvl_s.delete();
                run_k = 0;
            end else begin
                model_edge();
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                n_tests++;
                if (rnd_out !== m_state || rnd_valid !== m_valid) begin
                    n_fail++;
                    $display("FAIL cycle_cmp t=%0t: rnd_out=%h rnd_valid=%b, expected %h %b",
                             $time, rnd_out, rnd_valid, m_state, m_valid);
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] exp_seq[5];
        int pulses;
        exp_seq[0] = 8'h7F; exp_seq[1] = 8'h3F; exp_seq[2] = 8'h1F;
        exp_seq[3] = 8'h0F; exp_seq[4] = 8'h87;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", rnd_out, 8'hFF);
        check("reset_valid", W'(rnd_valid), 8'h00);
        cmp_en = 1'b1;
        rst = 1'b1;

        // Five separate presses in button mode
        for (int p = 0; p < 5; p++) begin
            pulses = 0;
            button = 1'b1;
            repeat (DEB + 6) begin @(negedge clk); pulses += int'(rnd_valid); end
            button = 1'b0;
            repeat (DEB + 6) begin @(negedge clk); pulses += int'(rnd_valid); end
            check($sformatf("press%0d_val", p), rnd_out, exp_seq[p]);
            check($sformatf("press%0d_pulses", p), W'(pulses), 8'h01);
        end

        // Held button: one step, landing on the LAT-th edge
        do_reset();
        button = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        check("hold_before_lat", rnd_out, 8'hFF);
        @(negedge clk);
        check("hold_at_lat", rnd_out, 8'h7F);
        pulses = int'(rnd_valid);
        repeat (100 - LAT) begin @(negedge clk); pulses += int'(rnd_valid); end
        check("hold_final", rnd_out, 8'h7F);
        check("hold_pulses", W'(pulses), 8'h01);
        button = 1'b0;
        repeat (DEB + 6) @(negedge clk);

        // Free-run div=3 from reset
        rst = 1'b0;
        mode = 1'b1;
        div = DW'(3);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("fr_before", rnd_out, 8'hFF);
        @(negedge clk);
        check("fr_step1", rnd_out, 8'h7F);
        check("fr_valid1", W'(rnd_valid), 8'h01);
        repeat (4) @(negedge clk);
        check("fr_step2", rnd_out, 8'h3F);
        repeat (4) @(negedge clk);
        check("fr_step3", rnd_out, 8'h1F);

        // Seed loads: zero guard, then a load coincident with a divider hit
        seed_load = 1'b1;
        seed = 8'h00;
        @(negedge clk);
        seed_load = 1'b0;
        check("load_zero", rnd_out, 8'hFF);
        repeat (3) @(negedge clk);
        check("load_no_step", rnd_out, 8'hFF);
        seed_load = 1'b1;
        seed = 8'hA5;
        @(negedge clk);
        seed_load = 1'b0;
        check("load_a5", rnd_out, 8'hA5);
        repeat (3) @(negedge clk);
        check("load_div_restart", rnd_out, 8'hA5);
        @(negedge clk);
        check("load_then_step", rnd_out, 8'h52);

        // Asynchronous reset in the middle of free-run
        div = DW'(0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out", rnd_out, 8'hFF);
        check("async_rst_valid", W'(rnd_valid), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("resume_out", rnd_out, 8'h7F);
        check("resume_valid", W'(rnd_valid), 8'h01);

`ifdef RNG_DEBOUNCE_EN
        // Short glitch is filtered, long press steps once
        mode = 1'b0;
        do_reset();
        pulses = 0;
        button = 1'b1;
        repeat (10) begin @(negedge clk); pulses += int'(rnd_valid); end
        button = 1'b0;
        repeat (30) begin @(negedge clk); pulses += int'(rnd_valid); end
        check("glitch_out", rnd_out, 8'hFF);
        check("glitch_pulses", W'(pulses), 8'h00);
        button = 1'b1;
        repeat (40) begin @(negedge clk); pulses += int'(rnd_valid); end
        button = 1'b0;
        repeat (30) begin @(negedge clk); pulses += int'(rnd_valid); end
        check("long_press_out", rnd_out, 8'h7F);
        check("long_press_pulses", W'(pulses), 8'h01);
`endif

        // Randomized run against the model
        mode = 1'b0;
        div = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < ((DEB > 0) ? 4 : 15)) button = ~button;
            seed_load = ($urandom_range(0, 59) == 0);
            seed = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 299) == 0) mode = ~mode;
            else if (!mode && $urandom_range(0, 29) == 0) div = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
            end
            @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
